// File: rtl/bayer_frame_ctrl_if.sv
// AXI4-Stream beat bundle used on both sides of bayer_frame_ctrl.
interface bayer_frame_ctrl_if #(
  parameter int unsigned DATA_W = 40
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/bayer_frame_ctrl.sv
// Frame gate for a Bayer AXI4-Stream: SOF sync, line/frame counting, error recovery.
// Optional saturating error counter output err_cnt enabled by BAYER_FRAME_CTRL_ERRCNT_EN.
module bayer_frame_ctrl #(
  parameter int unsigned DATA_W = 40,
  parameter int unsigned CNT_W  = 12
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             ctrl_start,
  input  logic             ctrl_stop,
  input  logic             ctrl_continuous,
  input  logic [CNT_W-1:0] cfg_line_beats,
  input  logic [CNT_W-1:0] cfg_frame_lines,
  bayer_frame_ctrl_if.slave  s_axis,
  bayer_frame_ctrl_if.master m_axis,
  output logic             line_odd,
  output logic             busy,
  output logic             frame_done,
  output logic             err_line,
  output logic             err_sof,
`ifdef BAYER_FRAME_CTRL_ERRCNT_EN
  output logic [15:0]      err_cnt,
`endif
  output logic [15:0]      frame_cnt
);

  typedef enum logic [1:0] {StIdle, StWaitSof, StPass, StFlush} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   x_q, y_q, lb_q, fl_q;
  logic [15:0]        frame_cnt_q;
  logic               stop_pend_q;
  logic               frame_done_q, err_line_q, err_sof_q;

  logic               in_sync, pass_en, fire;
  logic [CNT_W-1:0]   cfg_lb_eff, cfg_fl_eff, lb_cur, fl_cur, bx, by;
  logic               last_x, last_y, line_bad, sof_bad, frame_end, go_idle;
  logic               err_line_d, err_sof_d;
  state_e             beat_next;

  // Beat decode; in the sync states the SOF beat is treated as beat (0,0) of a new frame.
  always_comb begin
    cfg_lb_eff = (cfg_line_beats == '0) ? CNT_W'(1) : cfg_line_beats;
    cfg_fl_eff = (cfg_frame_lines == '0) ? CNT_W'(1) : cfg_frame_lines;
    in_sync    = (state_q == StWaitSof) || (state_q == StFlush);
    pass_en    = (state_q == StPass) || (in_sync && s_axis.tuser && !ctrl_stop);
    fire       = pass_en && s_axis.tvalid && m_axis.tready;
    lb_cur     = (state_q == StPass) ? lb_q : cfg_lb_eff;
    fl_cur     = (state_q == StPass) ? fl_q : cfg_fl_eff;
    bx         = s_axis.tuser ? '0 : x_q;
    by         = s_axis.tuser ? '0 : y_q;
    last_x     = (bx == lb_cur - CNT_W'(1));
    last_y     = (by == fl_cur - CNT_W'(1));
    line_bad   = (s_axis.tlast != last_x);
    sof_bad    = (state_q == StPass) && s_axis.tuser && ((x_q != '0) || (y_q != '0));
    frame_end  = fire && last_x && last_y && !line_bad;
    go_idle    = !ctrl_continuous || stop_pend_q || ctrl_stop;
    err_line_d = fire && line_bad;
    err_sof_d  = fire && sof_bad;
    if (line_bad)       beat_next = StFlush;
    else if (last_x && last_y) beat_next = go_idle ? StIdle : StWaitSof;
    else                beat_next = StPass;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:             if (ctrl_start && !ctrl_stop) state_d = StWaitSof;
      StWaitSof, StFlush: begin
        if (ctrl_stop) state_d = StIdle;
        else if (fire) state_d = beat_next;
      end
      StPass:             if (fire) state_d = beat_next;
      default:            state_d = StIdle;
    endcase
  end

  always_comb begin
    s_axis.tready = pass_en ? m_axis.tready : 1'b1;
    m_axis.tvalid = pass_en && s_axis.tvalid;
    m_axis.tdata  = s_axis.tdata[DATA_W-1:0];
    m_axis.tuser  = pass_en && (bx == '0) && (by == '0);
    m_axis.tlast  = pass_en && (last_x || s_axis.tlast);
    busy          = (state_q != StIdle);
    line_odd      = y_q[0];
    frame_done    = frame_done_q;
    err_line      = err_line_q;
    err_sof       = err_sof_q;
    frame_cnt     = frame_cnt_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      x_q          <= '0;
      y_q          <= '0;
      lb_q         <= CNT_W'(1);
      fl_q         <= CNT_W'(1);
      frame_cnt_q  <= '0;
      stop_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_line_q   <= 1'b0;
      err_sof_q    <= 1'b0;
    end else begin
      if (fire) begin
        if (line_bad || frame_end) begin
          x_q <= '0;
          y_q <= '0;
        end else begin
          x_q <= last_x ? '0 : bx + CNT_W'(1);
          y_q <= last_x ? by + CNT_W'(1) : by;
        end
        if (in_sync) begin
          lb_q <= cfg_lb_eff;
          fl_q <= cfg_fl_eff;
        end
      end
      if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (state_d == StIdle) stop_pend_q <= 1'b0;
      else if (ctrl_stop)    stop_pend_q <= 1'b1;
      frame_done_q <= frame_end;
      err_line_q   <= err_line_d;
      err_sof_q    <= err_sof_d;
    end
  end

`ifdef BAYER_FRAME_CTRL_ERRCNT_EN
  logic [15:0] err_cnt_q;
  logic [16:0] err_sum;

  always_comb begin
    err_sum = {1'b0, err_cnt_q} + 17'(err_line_d) + 17'(err_sof_d);
    err_cnt = err_cnt_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)          err_cnt_q <= '0;
    else if (ctrl_start) err_cnt_q <= '0;
    else                 err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_bayer_frame_ctrl.sv
// Directed scenarios with random payload and backpressure, checked against a frame-level model.
module tb_bayer_frame_ctrl;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        ctrl_start = 1'b0, ctrl_stop = 1'b0, ctrl_continuous = 1'b0;
  logic [11:0] cfg_line_beats = 12'd1, cfg_frame_lines = 12'd1;
  logic        line_odd, busy, frame_done, err_line, err_sof;
  logic [15:0] frame_cnt;

  bayer_frame_ctrl_if #(.DATA_W(40)) s_if ();
  bayer_frame_ctrl_if #(.DATA_W(40)) m_if ();

  bayer_frame_ctrl #(.DATA_W(40), .CNT_W(12)) dut (
    .aclk            (aclk),
    .areset          (areset),
    .ctrl_start      (ctrl_start),
    .ctrl_stop       (ctrl_stop),
    .ctrl_continuous (ctrl_continuous),
    .cfg_line_beats  (cfg_line_beats),
    .cfg_frame_lines (cfg_frame_lines),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .line_odd        (line_odd),
    .busy            (busy),
    .frame_done      (frame_done),
    .err_line        (err_line),
    .err_sof         (err_sof),
    .frame_cnt       (frame_cnt)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0, n_mis = 0;
  int n_done = 0, n_eline = 0, n_esof = 0, n_tlast = 0;
  int rdy_mode = 0;
  logic [42:0] mon_q[$];
  logic [42:0] exp_q[$];

  // {line_odd, tuser, tlast, tdata} of every transferred output beat
  always @(negedge aclk) begin
    if (m_if.tvalid && m_if.tready) begin
      mon_q.push_back({line_odd, m_if.tuser, m_if.tlast, m_if.tdata});
      if (m_if.tlast) n_tlast++;
    end
    if (frame_done) n_done++;
    if (err_line)   n_eline++;
    if (err_sof)    n_esof++;
  end

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      case (rdy_mode)
        1:       m_if.tready = ~m_if.tready;
        2:       m_if.tready = ($urandom_range(0, 3) != 0);
        default: m_if.tready = 1'b1;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic pulse_start();
    ctrl_start = 1'b1; cycles(1); ctrl_start = 1'b0;
  endtask

  task automatic pulse_stop();
    ctrl_stop = 1'b1; cycles(1); ctrl_stop = 1'b0;
  endtask

  task automatic clear();
    mon_q.delete(); exp_q.delete();
    n_done = 0; n_eline = 0; n_esof = 0; n_tlast = 0;
  endtask

  task automatic send(input logic [39:0] d, input logic u, input logic l);
    int k;
    s_if.tdata = d; s_if.tuser = u; s_if.tlast = l; s_if.tvalid = 1'b1;
    k = 0;
    do begin @(negedge aclk); k++; end while (!s_if.tready && k < 2000);
    if (!s_if.tready) check("send_timeout", 64'(s_if.tready), 64'd1);
    @(posedge aclk); #1;
    s_if.tvalid = 1'b0;
  endtask

  // Sends n beats of a frame with line length lb; beat err_idx carries an early tlast.
  task automatic send_seq(input int n, input int lb, input int err_idx, input bit pass,
                          input int stop_at);
    for (int i = 0; i < n; i++) begin
      logic [39:0] d;
      logic        u, l;
      if (i == stop_at) pulse_stop();
      d = {8'($urandom), $urandom};
      u = (i == 0);
      l = ((i % lb) == lb - 1) || (i == err_idx);
      send(d, u, l);
      if (pass) exp_q.push_back({1'((i / lb) % 2), u, l, d});
    end
  endtask

  task automatic cmp_stream(input string tag);
    int bad, n;
    check({tag, "_beats"}, 64'(mon_q.size()), 64'(exp_q.size()));
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    bad = -1;
    for (int i = 0; i < n; i++) if (bad < 0 && mon_q[i] !== exp_q[i]) bad = i;
    check({tag, "_first_bad_idx"}, 64'(bad), 64'(-1));
  endtask

  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
    cycles(3);
    @(negedge aclk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    areset = 1'b0;
    cycles(1);
    check("idle_sready", 64'(s_if.tready), 64'd1);
    check("idle_line_odd", 64'(line_odd), 64'd0);

    // 2048 x 4 single frame
    clear();
    cfg_line_beats = 12'd2048; cfg_frame_lines = 12'd4;
    pulse_start();
    check("start_busy", 64'(busy), 64'd1);
    send_seq(8192, 2048, -1, 1, -1);
    cycles(3);
    cmp_stream("big");
    check("big_tlast", 64'(n_tlast), 64'd4);
    check("big_done", 64'(n_done), 64'd1);
    check("big_frame_cnt", 64'(frame_cnt), 64'd1);
    check("big_idle", 64'(busy), 64'd0);

    // garbage before SOF, random backpressure
    clear();
    rdy_mode = 2;
    cfg_line_beats = 12'd4; cfg_frame_lines = 12'd3;
    pulse_start();
    for (int i = 0; i < 3; i++) send({8'($urandom), $urandom}, 1'b0, 1'b0);
    check("garbage_dropped", 64'(mon_q.size()), 64'd0);
    send_seq(12, 4, -1, 1, -1);
    cycles(3);
    cmp_stream("garbage");
    check("garbage_frame_cnt", 64'(frame_cnt), 64'd2);
    rdy_mode = 0;

    // early tlast on beat 1000 of line 1, then FLUSH, then a fresh frame
    clear();
    cfg_line_beats = 12'd1200; cfg_frame_lines = 12'd3;
    pulse_start();
    send_seq(2201, 1200, 2200, 1, -1);
    cycles(3);
    check("eline_pulse", 64'(n_eline), 64'd1);
    check("eline_flush_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 5; i++) send({8'($urandom), $urandom}, 1'b0, 1'b0);
    cfg_line_beats = 12'd3; cfg_frame_lines = 12'd2;
    send_seq(6, 3, -1, 1, -1);
    cycles(3);
    cmp_stream("eline");
    check("eline_done", 64'(n_done), 64'd1);
    check("eline_frame_cnt", 64'(frame_cnt), 64'd3);

    // continuous with stop during frame 2; a third frame is dropped
    clear();
    ctrl_continuous = 1'b1;
    cfg_line_beats = 12'd5; cfg_frame_lines = 12'd2;
    pulse_start();
    send_seq(10, 5, -1, 1, -1);
    cycles(2);
    check("cont_busy_between", 64'(busy), 64'd1);
    send_seq(10, 5, -1, 1, 3);
    cycles(3);
    check("cont_frame_cnt", 64'(frame_cnt), 64'd5);
    check("cont_idle", 64'(busy), 64'd0);
    send_seq(10, 5, -1, 0, -1);
    cycles(3);
    cmp_stream("cont");
    check("cont_done", 64'(n_done), 64'd2);
    ctrl_continuous = 1'b0;

    // ready toggling every cycle, line parity 0,1,0,1
    clear();
    rdy_mode = 1;
    cfg_line_beats = 12'd3; cfg_frame_lines = 12'd4;
    pulse_start();
    send_seq(12, 3, -1, 1, -1);
    cycles(3);
    cmp_stream("toggle");
    check("toggle_tlast", 64'(n_tlast), 64'd4);
    rdy_mode = 0;

    // zero configuration acts as a 1x1 frame
    clear();
    cfg_line_beats = 12'd0; cfg_frame_lines = 12'd0;
    pulse_start();
    send_seq(1, 1, -1, 1, -1);
    cycles(3);
    cmp_stream("zero_cfg");
    check("zero_cfg_done", 64'(n_done), 64'd1);

    // SOF in mid-frame restarts the frame
    clear();
    cfg_line_beats = 12'd4; cfg_frame_lines = 12'd2;
    pulse_start();
    send_seq(3, 4, -1, 1, -1);
    send_seq(8, 4, -1, 1, -1);
    cycles(3);
    cmp_stream("esof");
    check("esof_pulse", 64'(n_esof), 64'd1);
    check("esof_done", 64'(n_done), 64'd1);
    check("esof_frame_cnt", 64'(frame_cnt), 64'd8);

    // simultaneous start and stop in IDLE
    ctrl_start = 1'b1; ctrl_stop = 1'b1;
    cycles(1);
    ctrl_start = 1'b0; ctrl_stop = 1'b0;
    cycles(1);
    check("startstop_idle", 64'(busy), 64'd0);

    // reset held two cycles mid-line
    clear();
    cfg_line_beats = 12'd8; cfg_frame_lines = 12'd2;
    pulse_start();
    send_seq(5, 8, -1, 1, -1);
    areset = 1'b1;
    cycles(2);
    @(negedge aclk);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_mvalid", 64'(m_if.tvalid), 64'd0);
    check("mrst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("mrst_line_odd", 64'(line_odd), 64'd0);
    check("mrst_pulses", 64'({frame_done, err_line, err_sof}), 64'd0);
    cycles(1);
    areset = 1'b0;
    cycles(1);
    pulse_start();
    send_seq(16, 8, -1, 1, -1);
    cycles(3);
    cmp_stream("after_rst");
    check("after_rst_frame_cnt", 64'(frame_cnt), 64'd1);
    check("after_rst_idle", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
